// File: rtl/split_pkg.sv
// split_pkg: shared defaults and helpers for the KPN split node.
//   DATA_W_DEF  default token width
//   DEPTH_DEF   default per-branch FIFO depth (power of two, >= 2)
//   STATS_W     width of the optional token counters (SPLIT_STATS_EN)
//   ptr_width() FIFO pointer width for a given depth
package split_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned STATS_W    = 16;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/split_fifo.sv
// split_fifo: single-clock FIFO with a registered head output.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, data_i  write request and token (ignored when full)
//   pop_i           read request (ignored when empty)
//   full_o, empty_o occupancy flags
//   head_o          registered head token; holds last presented value when
//                   empty, 0 after reset
module split_fifo
  import split_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              push_ok, pop_ok;

  assign full_o     = (count_q == CNT_FULL);
  assign empty_o    = (count_q == '0);
  assign head_o     = head_q;
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_nxt;

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // The head register mirrors mem[rd_ptr] but is loaded one edge early:
    // on a pop it takes the next stored token, or the incoming token when
    // the popped one was the last; a push into an empty FIFO bypasses
    // memory so the token shows after a single edge.
    if (pop_ok) begin
      if (count_q > CNT_ONE) begin
        head_d = mem_q[rd_ptr_nxt];
      end else if (push_ok) begin
        head_d = data_i;
      end
    end else if (push_ok && empty_o) begin
      head_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/split_module.sv
// split_module: KPN split node duplicating each input token onto two
// independently buffered output channels.
//   clk, rst_n                          clock, async active-low reset
//   entry_1 / _valid / _ready           input channel
//   output_1 / _valid / _ready          branch-1 channel
//   output_2 / _valid / _ready          branch-2 channel
//   tokens_in, tokens_out_1/2           push/pop counters, present only
//                                       when SPLIT_STATS_EN is defined
module split_module
  import split_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] entry_1,
  input  logic              entry_1_valid,
  output logic              entry_1_ready,
  output logic [DATA_W-1:0] output_1,
  output logic              output_1_valid,
  input  logic              output_1_ready,
  output logic [DATA_W-1:0] output_2,
  output logic              output_2_valid,
  input  logic              output_2_ready
`ifdef SPLIT_STATS_EN
  ,
  output logic [STATS_W-1:0] tokens_in,
  output logic [STATS_W-1:0] tokens_out_1,
  output logic [STATS_W-1:0] tokens_out_2
`endif
);

  logic full1, full2, empty1, empty2;
  logic push, pop1, pop2;

  // Acceptance uses only registered occupancy; a pop in the same cycle does
  // not free a slot early. rst_n gating keeps ready low during reset.
  assign entry_1_ready  = rst_n && !full1 && !full2;
  assign push           = entry_1_valid && entry_1_ready;
  assign output_1_valid = !empty1;
  assign output_2_valid = !empty2;
  assign pop1           = output_1_valid && output_1_ready;
  assign pop2           = output_2_valid && output_2_ready;

  split_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_1 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (entry_1),
    .pop_i   (pop1),
    .full_o  (full1),
    .empty_o (empty1),
    .head_o  (output_1)
  );

  split_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_2 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (entry_1),
    .pop_i   (pop2),
    .full_o  (full2),
    .empty_o (empty2),
    .head_o  (output_2)
  );

`ifdef SPLIT_STATS_EN
  logic [STATS_W-1:0] tokens_in_q, tokens_in_d;
  logic [STATS_W-1:0] tokens_out_1_q, tokens_out_1_d;
  logic [STATS_W-1:0] tokens_out_2_q, tokens_out_2_d;

  always_comb begin
    tokens_in_d    = tokens_in_q;
    tokens_out_1_d = tokens_out_1_q;
    tokens_out_2_d = tokens_out_2_q;
    if (push) tokens_in_d    = tokens_in_q + STATS_W'(1);
    if (pop1) tokens_out_1_d = tokens_out_1_q + STATS_W'(1);
    if (pop2) tokens_out_2_d = tokens_out_2_q + STATS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tokens_in_q    <= '0;
      tokens_out_1_q <= '0;
      tokens_out_2_q <= '0;
    end else begin
      tokens_in_q    <= tokens_in_d;
      tokens_out_1_q <= tokens_out_1_d;
      tokens_out_2_q <= tokens_out_2_d;
    end
  end

  assign tokens_in    = tokens_in_q;
  assign tokens_out_1 = tokens_out_1_q;
  assign tokens_out_2 = tokens_out_2_q;
`endif

endmodule

// File: tb/tb_split_module.sv
module tb_split_module;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] entry_1;
  logic        entry_1_valid;
  logic        entry_1_ready;
  logic [15:0] output_1;
  logic        output_1_valid;
  logic        output_1_ready;
  logic [15:0] output_2;
  logic        output_2_valid;
  logic        output_2_ready;
`ifdef SPLIT_STATS_EN
  logic [15:0] tokens_in;
  logic [15:0] tokens_out_1;
  logic [15:0] tokens_out_2;
`endif

  split_module #(.DATA_W(16), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .entry_1        (entry_1),
    .entry_1_valid  (entry_1_valid),
    .entry_1_ready  (entry_1_ready),
    .output_1       (output_1),
    .output_1_valid (output_1_valid),
    .output_1_ready (output_1_ready),
    .output_2       (output_2),
    .output_2_valid (output_2_valid),
    .output_2_ready (output_2_ready)
`ifdef SPLIT_STATS_EN
    ,
    .tokens_in      (tokens_in),
    .tokens_out_1   (tokens_out_1),
    .tokens_out_2   (tokens_out_2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue per branch plus the last value each branch
  // presented (what an empty branch keeps showing).
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic [15:0] last1 = '0;
  logic [15:0] last2 = '0;
  int n_in = 0, n_o1 = 0, n_o2 = 0;

  function automatic void model_clear();
    q1.delete();
    q2.delete();
    last1 = '0;
    last2 = '0;
    n_in  = 0;
    n_o1  = 0;
    n_o2  = 0;
  endfunction

  function automatic logic model_ready();
    return (q1.size() < DEPTH) && (q2.size() < DEPTH);
  endfunction

  // Called just after a falling edge: drive, step one rising edge, update
  // the model, and return just after the next falling edge.
  task automatic tick(input logic v, input logic [15:0] d,
                      input logic r1, input logic r2, output logic acc);
    logic p1, p2;
    entry_1_valid  = v;
    entry_1        = d;
    output_1_ready = r1;
    output_2_ready = r2;
    #1;
    acc = v && model_ready();
    p1  = r1 && (q1.size() != 0);
    p2  = r2 && (q2.size() != 0);
    @(posedge clk);
    if (p1) begin void'(q1.pop_front()); n_o1++; end
    if (p2) begin void'(q2.pop_front()); n_o2++; end
    if (acc) begin q1.push_back(d); q2.push_back(d); n_in++; end
    if (q1.size() != 0) last1 = q1[0];
    if (q2.size() != 0) last2 = q2[0];
    @(negedge clk);
  endtask

  task automatic do_reset();
    entry_1_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    entry_1_valid  = 1'b0;
    entry_1        = '0;
    output_1_ready = 1'b0;
    output_2_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (entry_1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b expected 0", entry_1_ready); end
    n_checks++;
    if ({output_1_valid, output_2_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_valids: got %b expected 00", {output_1_valid, output_2_valid}); end
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    n_checks++;
    if (output_1 !== 16'd0 || output_2 !== 16'd0) begin n_fail++; $display("FAIL idle_data: got %0d/%0d expected 0/0", output_1, output_2); end
    n_checks++;
    if ({output_1_valid, output_2_valid} !== 2'b00) begin n_fail++; $display("FAIL idle_valids: got %b expected 00", {output_1_valid, output_2_valid}); end
    n_checks++;
    if (entry_1_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b expected 1", entry_1_ready); end
  endtask

  task automatic test_stream();
    logic [15:0] toks[3];
    logic acc;
    toks[0] = 16'd10; toks[1] = 16'd50; toks[2] = 16'd90;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (entry_1_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, entry_1_ready); end
      tick(1'b1, toks[i], 1'b1, 1'b1, acc);
      n_checks++;
      if (output_1_valid !== 1'b1 || output_1 !== toks[i]) begin n_fail++; $display("FAIL stream_b1[%0d]: got v=%b d=%0d expected v=1 d=%0d", i, output_1_valid, output_1, toks[i]); end
      n_checks++;
      if (output_2_valid !== 1'b1 || output_2 !== toks[i]) begin n_fail++; $display("FAIL stream_b2[%0d]: got v=%b d=%0d expected v=1 d=%0d", i, output_2_valid, output_2, toks[i]); end
    end
    tick(1'b0, 16'hdead, 1'b1, 1'b1, acc);
    n_checks++;
    if ({output_1_valid, output_2_valid} !== 2'b00 || output_1 !== 16'd90 || output_2 !== 16'd90) begin
      n_fail++; $display("FAIL stream_drained: got v=%b%b d=%0d/%0d expected v=00 d=90/90", output_1_valid, output_2_valid, output_1, output_2);
    end
  endtask

  task automatic test_stall();
    logic acc;
    for (int i = 1; i <= DEPTH; i++) begin
      tick(1'b1, 16'(i), 1'b1, 1'b0, acc);
      n_checks++;
      if (output_1_valid !== 1'b1 || output_1 !== 16'(i)) begin n_fail++; $display("FAIL stall_b1[%0d]: got v=%b d=%0d expected v=1 d=%0d", i, output_1_valid, output_1, i); end
      n_checks++;
      if (output_2_valid !== 1'b1 || output_2 !== 16'd1) begin n_fail++; $display("FAIL stall_b2_head[%0d]: got v=%b d=%0d expected v=1 d=1", i, output_2_valid, output_2); end
      n_checks++;
      if (entry_1_ready !== (i < DEPTH)) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b expected %b", i, entry_1_ready, (i < DEPTH)); end
    end
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 16'(DEPTH + 1), 1'b1, 1'b0, acc);
      n_checks++;
      if (entry_1_ready !== 1'b0 || output_1_valid !== 1'b0 || output_1 !== 16'(DEPTH)) begin
        n_fail++; $display("FAIL stall_held[%0d]: got rdy=%b v1=%b d1=%0d expected rdy=0 v1=0 d1=%0d", k, entry_1_ready, output_1_valid, output_1, DEPTH);
      end
    end
  endtask

  task automatic test_release();
    logic [15:0] got2[$];
    logic v, acc;
    v = 1'b1;
    for (int c = 0; c < 3 * DEPTH + 4; c++) begin
      n_checks++;
      if (entry_1_ready !== model_ready()) begin n_fail++; $display("FAIL release_ready[%0d]: got %b expected %b", c, entry_1_ready, model_ready()); end
      if (output_2_valid) got2.push_back(output_2);
      tick(v, 16'd100, 1'b1, 1'b1, acc);
      if (acc) v = 1'b0;
    end
    n_checks++;
    if (got2.size() != DEPTH + 1) begin
      n_fail++; $display("FAIL release_count: got %0d expected %0d", got2.size(), DEPTH + 1);
    end else begin
      for (int i = 0; i < DEPTH + 1; i++) begin
        logic [15:0] exp;
        exp = (i < DEPTH) ? 16'(i + 1) : 16'd100;
        n_checks++;
        if (got2[i] !== exp) begin n_fail++; $display("FAIL release_order[%0d]: got %0d expected %0d", i, got2[i], exp); end
      end
    end
  endtask

  task automatic test_random();
    logic acc;
    for (int c = 0; c < 400; c++) begin
      tick(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), acc);
      n_checks++;
      if (entry_1_ready !== model_ready()) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, entry_1_ready, model_ready()); end
      n_checks++;
      if (output_1_valid !== (q1.size() != 0) || output_1 !== last1) begin
        n_fail++; $display("FAIL rand_b1[%0d]: got v=%b d=%0d expected v=%b d=%0d", c, output_1_valid, output_1, (q1.size() != 0), last1);
      end
      n_checks++;
      if (output_2_valid !== (q2.size() != 0) || output_2 !== last2) begin
        n_fail++; $display("FAIL rand_b2[%0d]: got v=%b d=%0d expected v=%b d=%0d", c, output_2_valid, output_2, (q2.size() != 0), last2);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    tick(1'b1, 16'h1111, 1'b0, 1'b0, acc);
    tick(1'b1, 16'h2222, 1'b0, 1'b0, acc);
    n_checks++;
    if ({output_1_valid, output_2_valid} !== 2'b11) begin n_fail++; $display("FAIL mid_prefill: got %b expected 11", {output_1_valid, output_2_valid}); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (output_1 !== 16'd0 || output_2 !== 16'd0 || {output_1_valid, output_2_valid, entry_1_ready} !== 3'b000) begin
      n_fail++; $display("FAIL mid_async_reset: got d=%0d/%0d v=%b%b rdy=%b expected 0/0 00 0", output_1, output_2, output_1_valid, output_2_valid, entry_1_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 16'h3333, 1'b1, 1'b1, acc);
      n_checks++;
      if ({output_1_valid, output_2_valid} !== 2'b00 || output_1 !== 16'd0 || output_2 !== 16'd0) begin
        n_fail++; $display("FAIL mid_no_stale[%0d]: got v=%b%b d=%0d/%0d expected 00 0/0", c, output_1_valid, output_2_valid, output_1, output_2);
      end
    end
    tick(1'b1, 16'h0077, 1'b0, 1'b0, acc);
    n_checks++;
    if (output_1 !== 16'h0077 || output_2 !== 16'h0077 || {output_1_valid, output_2_valid} !== 2'b11) begin
      n_fail++; $display("FAIL mid_first_after: got d=%h/%h v=%b%b expected 0077/0077 11", output_1, output_2, output_1_valid, output_2_valid);
    end
  endtask

`ifdef SPLIT_STATS_EN
  task automatic test_stats();
    logic acc;
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 16'(i + 7), 1'b1, 1'b1, acc);
    for (int i = 0; i < 2; i++) tick(1'b0, 16'h0, 1'b1, 1'b1, acc);
    n_checks++;
    if (tokens_in !== 16'd3 || tokens_out_1 !== 16'd3 || tokens_out_2 !== 16'd3) begin
      n_fail++; $display("FAIL stats_counts: got %0d/%0d/%0d expected 3/3/3", tokens_in, tokens_out_1, tokens_out_2);
    end
  endtask
`endif

  initial begin
    rst_n          = 1'b0;
    entry_1_valid  = 1'b0;
    entry_1        = '0;
    output_1_ready = 1'b0;
    output_2_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_release();
    test_random();
    test_reset_mid();
`ifdef SPLIT_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/split_module.md
Name: split_module

Overview:
- Kahn-process-network (KPN) split node: duplicates every token on a single 16-bit input channel onto two independent output channels.
- Each output branch has its own small FIFO, so one slow consumer does not stall the other until that branch's FIFO fills.
- Sits between a producer process and two consumer processes in the KPN fabric.

Parameters:
- DATA_W, 16, token width in bits.
- DEPTH, 4, per-branch FIFO depth in tokens; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- entry_1  in  DATA_W  input token.
- entry_1_valid  in  1  input token present.
- entry_1_ready  out  1  split accepts the token this cycle.
- output_1  out  DATA_W  branch-1 token.
- output_1_valid  out  1  branch-1 token present.
- output_1_ready  in  1  branch-1 consumer accepts.
- output_2  out  DATA_W  branch-2 token.
- output_2_valid  out  1  branch-2 token present.
- output_2_ready  in  1  branch-2 consumer accepts.

Behaviour:
- Reset (rst_n low, asynchronous): both FIFOs empty, pointers and counts 0, output_1 = output_2 = 0, both valids 0, entry_1_ready 0 while reset is asserted. Reset mid-transfer discards all buffered tokens.
- entry_1_ready = !full1 && !full2, decided combinationally from registered state only. It never depends on the output ready inputs, so there is no pop look-through.
- Push: when entry_1_valid && entry_1_ready, entry_1 is written into both FIFOs in the same cycle. Duplication is atomic; a token never enters only one branch.
- Pop for branch n: occurs when output_n_valid && output_n_ready; the branch's read pointer advances.
- output_n_valid = branch FIFO non-empty.
- output_n is driven from a registered head. When empty it holds the last presented value, which is 0 after reset.
- Latency: a token pushed at edge k is visible on both outputs with valid high after edge k, i.e. one cycle, when that branch was empty.
- Simultaneous push and pop on the same branch: count unchanged; data order preserved.
- Full branch: entry_1_ready drops. The other branch keeps draining normally.
- Pointers wrap modulo DEPTH. Per-branch count range is 0..DEPTH.
- Order: each branch delivers tokens in exact input order, with no loss and no duplication within a branch.
- Valid/data stability: once output_n_valid is high, output_n is held until the pop occurs.
- entry_1 is sampled only on an accepting edge; changes at other times are ignored.

Optional Feature:
- Macro: SPLIT_STATS_EN.
- Defined: adds outputs tokens_in (16 bit), tokens_out_1 (16 bit) and tokens_out_2 (16 bit).
  - Each counts accepted pushes, and pops per branch, respectively.
  - Counters wrap at 2^16 and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package split_pkg: DATA_W default, DEPTH default, and a function returning the pointer width, clog2(DEPTH).
- One sub-module, split_fifo: single-clock FIFO with push, pop, full, empty and a registered head. It is instantiated twice, once per branch.
- split_module contains the accept logic, the shared push and the optional counters.

Test Plan:
- Reset then idle: after rst_n rises with entry_1_valid = 0 → output_1 = output_2 = 0, both valids 0, entry_1_ready = 1.
- Stream 10, 50, 90 with both readies held high → each branch presents 10, 50, 90 in order, each one cycle after acceptance; no gaps or repeats.
- Branch 2 stalled (output_2_ready = 0), branch 1 ready, push 1..DEPTH → branch 1 delivers all tokens; entry_1_ready goes 0 after DEPTH accepts; the next token is held.
- Release branch 2 from the previous scenario → branch 2 delivers 1..DEPTH in order; entry_1_ready returns to 1 once branch 2 is no longer full.
- Assert rst_n low mid-stream with both FIFOs partly full → outputs immediately 0 and valids 0; after release the FIFOs are empty and no stale tokens appear.
- With SPLIT_STATS_EN, push 3 tokens with both branches draining → tokens_in = tokens_out_1 = tokens_out_2 = 3.
